tipi_mailbox: RTL
=================

# tipi_mailbox

Parametrised successor to the fixed four-register TI/RPi exchange. It provides CHANNELS register pairs of WIDTH bits: one TI→RPi register and one RPi→TI register per channel. The TI side is a synchronous strobe interface; the RPi side is a framed serial link sampled in the system clock domain. Per-channel pending flags and an interrupt tell the TI when the RPi has delivered new data.

## Interface
Parameters:
- WIDTH, 8: bits per register and per serial frame (≥2).
- CHANNELS, 2: number of register pairs (≥1). CW = max(1, clog2(CHANNELS)).
- SYNC_STAGES, 2: flip-flop stages on every RPi input (≥2).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high; clears all state.
- ti_wr  in  1  one-cycle strobe; writes ti_wdata into TI→RPi reg[ti_ch].
- ti_rd  in  1  one-cycle strobe; reads RPi→TI reg[ti_ch] and clears pending[ti_ch].
- ti_ch  in  CW  channel index; sampled with ti_wr/ti_rd. Indices ≥CHANNELS: write ignored, read returns 0.
- ti_wdata  in  WIDTH  write data.
- ti_rdata  out  WIDTH  read data, registered; holds its value until the next ti_rd.
- ti_irq  out  1  OR of all pending flags, registered.
- pending  out  CHANNELS  per-channel new-data flags.
- r_clk  in  1  async serial bit clock from the RPi.
- r_le  in  1  async frame enable; high for the whole frame.
- r_rt  in  1  async frame direction: 1 = TI→RPi (read-out), 0 = RPi→TI (write-in).
- r_sel  in  CW  async channel select; must be stable while r_le is high.
- r_dout  in  1  async serial data, RPi→block.
- r_din  out  1  serial data, block→RPi.
- busy  out  1  high while a frame is active.
- frame_err  out  1  sticky flag: a write-in frame ended with a bit count ≠ WIDTH. Cleared only by reset.

## Operation
- All RPi inputs pass through SYNC_STAGES flops. Edge detection runs on the synchronised r_clk and r_le.
- State machine states: IDLE, SHIFT_OUT, SHIFT_IN, COMMIT.
- IDLE, r_le rising:
  - Latch sel and rt into frame registers; clear the bit counter; set busy.
  - rt=1: load shreg from TI→RPi reg[sel]; r_din = shreg MSB; go to SHIFT_OUT.
  - rt=0: clear shreg; go to SHIFT_IN.
- SHIFT_OUT, each r_clk rising: shift shreg left by one; r_din = new MSB; increment the counter (saturates at WIDTH).
  - After WIDTH edges r_din = 0.
  - r_le falling → IDLE; busy cleared.
- SHIFT_IN, each r_clk rising: shreg = {shreg[WIDTH-2:0], r_dout}; increment the counter (saturates at WIDTH+1).
  - r_le falling with counter == WIDTH → COMMIT.
  - r_le falling with any other count → set frame_err, discard shreg, go to IDLE.
- COMMIT (one cycle): RPi→TI reg[sel] = shreg; pending[sel] = 1; go to IDLE; busy cleared.
- Frames with sel ≥ CHANNELS run normally. Read-out shifts zeros; commit is dropped and pending is unchanged.
- TI write to a channel during SHIFT_OUT on that channel updates the register only. The snapshot in shreg is unaffected; the next frame carries the new value.
- ti_rd in the same cycle as COMMIT to the same channel:
  - ti_rdata gets the pre-commit value.
  - pending ends set (commit wins over clear).
- ti_rd in the same cycle as COMMIT to a different channel: both take effect.
- r_clk edges while IDLE are ignored. An r_le rising edge while not IDLE is impossible by construction; a falling edge always precedes it.
- Reset mid-frame: state returns to IDLE immediately; the frame is discarded and no commit occurs.

## Timing
- Reset values: ti_rdata = 0, ti_irq = 0, pending = 0, r_din = 0, busy = 0, frame_err = 0, all registers 0, state IDLE.
- ti_wr: register updated at the edge sampling the strobe. It is visible to a read-out frame loaded on any later cycle.
- ti_rd → ti_rdata valid 1 cycle later; pending cleared on the same edge.
- COMMIT → pending set at that edge; ti_irq high 1 cycle later.
- RPi pin edge → internal edge event: SYNC_STAGES+1 cycles. r_din settles SYNC_STAGES+2 cycles after an r_clk rise.
- RPi timing requirements:
  - r_clk high and low times ≥ SYNC_STAGES+3 clk periods.
  - The RPi samples r_din before its next r_clk rise.
  - r_le setup and hold around the first and last r_clk rise ≥ SYNC_STAGES+3 clk periods.
- Throughput: one bit per r_clk period; no back-pressure.

## Test plan
- Reset → all outputs 0. TI write ch1=0xA5, then a read-out frame with sel=1 → r_din samples 1,0,1,0,0,1,0,1. busy high for the whole frame.
- Write-in frame, sel=0, shifting 0x3C → pending=01, ti_irq=1. ti_rd ch0 → ti_rdata=0x3C next cycle; pending=00 and ti_irq=0 one cycle later.
- Write-in frame of 7 bits → frame_err=1, reg unchanged, pending=0. A following 8-bit frame of 0x81 commits normally while frame_err stays 1.
- ti_rd ch0 forced into the COMMIT cycle of a ch0 frame (old 0x11, new 0x22) → ti_rdata=0x11, pending[0]=1. A second ti_rd returns 0x22.
- TI writes ch0=0x55 at mid-bit 3 of a ch0 read-out of 0xF0 → RPi receives 0xF0. The next frame returns 0x55.
- Reset asserted at bit 4 of a write-in frame → state IDLE, busy=0, no pending. WIDTH=16, CHANNELS=4 build passes the first two scenarios on ch3.

Source files
------------

// File: rtl/tipi_mailbox.sv
// tipi_mailbox: parametrised TI/RPi register exchange.
//
// Provides CHANNELS pairs of WIDTH-bit registers. The TI side writes the
// TI->RPi registers and reads the RPi->TI registers through one-cycle strobes.
// The RPi side reaches them over a framed serial link (r_clk/r_le/r_rt/r_sel/
// r_dout/r_din) that is sampled in the clk domain through SYNC_STAGES flops.
// A committed write-in frame sets pending[ch]; ti_irq is the registered OR
// of all pending flags.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   ti_wr, ti_rd     TI write / read strobes for channel ti_ch
//   ti_ch, ti_wdata  TI channel index and write data
//   ti_rdata         registered read data, held until the next ti_rd
//   ti_irq, pending  interrupt and per-channel new-data flags
//   r_clk, r_le      RPi serial bit clock and frame enable (asynchronous)
//   r_rt, r_sel      RPi frame direction (1 = read-out) and channel select
//   r_dout, r_din    RPi serial data in / out
//   busy, frame_err  frame active / sticky bad-length write-in indication
module tipi_mailbox #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ti_wr,
  input  logic                ti_rd,
  input  logic [CW-1:0]       ti_ch,
  input  logic [WIDTH-1:0]    ti_wdata,
  output logic [WIDTH-1:0]    ti_rdata,
  output logic                ti_irq,
  output logic [CHANNELS-1:0] pending,
  input  logic                r_clk,
  input  logic                r_le,
  input  logic                r_rt,
  input  logic [CW-1:0]       r_sel,
  input  logic                r_dout,
  output logic                r_din,
  output logic                busy,
  output logic                frame_err
);

  localparam int CNTW = $clog2(WIDTH + 2);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SHIFT_OUT = 2'd1;
  localparam logic [1:0] SHIFT_IN  = 2'd2;
  localparam logic [1:0] COMMIT    = 2'd3;

  logic [SYNC_STAGES-1:0]         rClkSync_q, rLeSync_q, rRtSync_q, rDoutSync_q;
  logic [SYNC_STAGES-1:0][CW-1:0] rSelSync_q;
  logic                           rClkPrev_q, rLePrev_q;

  logic                rClkS, rLeS, rRtS, rDoutS;
  logic [CW-1:0]       rSelS;
  logic                clkRise, leRise, leFall;

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]       sel_q, sel_d;
  logic                rDin_q, rDin_d;
  logic                busy_q, busy_d;
  logic                frameErr_q, frameErr_d;
  logic                commit;

  logic [WIDTH-1:0]    tiToRpi_q [CHANNELS];
  logic [WIDTH-1:0]    rpiToTi_q [CHANNELS];
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic                irq_q;
  logic [WIDTH-1:0]    txSel, rxTi;

  // Every RPi input goes through the same synchroniser depth so that data,
  // select and direction line up with the r_clk / r_le edges derived from them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rClkSync_q  <= '0;
      rLeSync_q   <= '0;
      rRtSync_q   <= '0;
      rDoutSync_q <= '0;
      rSelSync_q  <= '0;
      rClkPrev_q  <= 1'b0;
      rLePrev_q   <= 1'b0;
    end else begin
      rClkSync_q  <= {rClkSync_q[SYNC_STAGES-2:0], r_clk};
      rLeSync_q   <= {rLeSync_q[SYNC_STAGES-2:0], r_le};
      rRtSync_q   <= {rRtSync_q[SYNC_STAGES-2:0], r_rt};
      rDoutSync_q <= {rDoutSync_q[SYNC_STAGES-2:0], r_dout};
      rSelSync_q  <= {rSelSync_q[SYNC_STAGES-2:0], r_sel};
      rClkPrev_q  <= rClkSync_q[SYNC_STAGES-1];
      rLePrev_q   <= rLeSync_q[SYNC_STAGES-1];
    end
  end

  assign rClkS   = rClkSync_q[SYNC_STAGES-1];
  assign rLeS    = rLeSync_q[SYNC_STAGES-1];
  assign rRtS    = rRtSync_q[SYNC_STAGES-1];
  assign rDoutS  = rDoutSync_q[SYNC_STAGES-1];
  assign rSelS   = rSelSync_q[SYNC_STAGES-1];
  assign clkRise = rClkS & ~rClkPrev_q;
  assign leRise  = rLeS & ~rLePrev_q;
  assign leFall  = ~rLeS & rLePrev_q;

  // Channel lookups by loop so out-of-range indices simply match nothing:
  // read-out of such a channel loads zeros, a TI read returns zero, and a
  // commit or write to it touches no register.
  always_comb begin
    txSel     = '0;
    rxTi      = '0;
    pending_d = pending_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rSelS == CW'(i)) txSel = tiToRpi_q[i];
      if (ti_ch == CW'(i)) rxTi = rpiToTi_q[i];
      if (ti_rd && ti_ch == CW'(i)) pending_d[i] = 1'b0;
      if (commit && sel_q == CW'(i)) pending_d[i] = 1'b1;
    end
    rdata_d = ti_rd ? rxTi : rdata_q;
  end

  // Frame state machine. In SHIFT_OUT the register shifts zeros in from the
  // bottom, so r_din naturally drops to 0 once WIDTH bits have gone out.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    rDin_d     = rDin_q;
    busy_d     = busy_q;
    frameErr_d = frameErr_q;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (leRise) begin
          sel_d  = rSelS;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (rRtS) begin
            shreg_d = txSel;
            rDin_d  = txSel[WIDTH-1];
            state_d = SHIFT_OUT;
          end else begin
            shreg_d = '0;
            rDin_d  = 1'b0;
            state_d = SHIFT_IN;
          end
        end
      end
      SHIFT_OUT: begin
        if (leFall) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          rDin_d  = 1'b0;
        end else if (clkRise) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          rDin_d  = shreg_q[WIDTH-2];
          if (cnt_q != CNTW'(WIDTH)) cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT_IN: begin
        if (leFall) begin
          if (cnt_q == CNTW'(WIDTH)) begin
            state_d = COMMIT;
          end else begin
            frameErr_d = 1'b1;
            shreg_d    = '0;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end else if (clkRise) begin
          shreg_d = {shreg_q[WIDTH-2:0], rDoutS};
          if (cnt_q != CNTW'(WIDTH + 1)) cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Frame registers and TI-side status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      rDin_q     <= 1'b0;
      busy_q     <= 1'b0;
      frameErr_q <= 1'b0;
      pending_q  <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      rDin_q     <= rDin_d;
      busy_q     <= busy_d;
      frameErr_q <= frameErr_d;
      pending_q  <= pending_d;
      rdata_q    <= rdata_d;
      irq_q      <= |pending_q;
    end
  end

  // Register file. A TI write during a read-out only changes the register;
  // the frame already holds its own snapshot in shreg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tiToRpi_q[i] <= '0;
        rpiToTi_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ti_wr && ti_ch == CW'(i)) tiToRpi_q[i] <= ti_wdata;
        if (commit && sel_q == CW'(i)) rpiToTi_q[i] <= shreg_q;
      end
    end
  end

  assign ti_rdata  = rdata_q;
  assign ti_irq    = irq_q;
  assign pending   = pending_q;
  assign r_din     = rDin_q;
  assign busy      = busy_q;
  assign frame_err = frameErr_q;

endmodule
